// File: rtl/lcd_ctrl.sv
// lcd_ctrl: turns each GO toggle of the LSU LCD register into one timed HD44780 write cycle
module lcd_ctrl #(
  parameter int T_AS   = 2,
  parameter int T_PW   = 25,
  parameter int T_H    = 2,
  parameter int T_EXEC = 2500,
  parameter int T_CLR  = 82000,
  parameter int CNT_W  = 17
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] io_lcd_i,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic        lcd_busy_o,
  output logic        lcd_done_o
);
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, WAIT} state_e;
  localparam logic [CNT_W-1:0] AS_M1   = CNT_W'(T_AS - 1);
  localparam logic [CNT_W-1:0] PW_M1   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] H_M1    = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] EXEC_M1 = CNT_W'(T_EXEC - 1);
  localparam logic [CNT_W-1:0] CLR_M1  = CNT_W'(T_CLR - 1);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             go_ack_q, go_ack_d;
  logic [7:0]       data_q, data_d;
  logic             rs_q, rs_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             on_q;
  logic             on, go, expired, is_clr;
  logic             unused_io;
  assign on        = io_lcd_i[31];
  assign go        = io_lcd_i[10];
  assign unused_io = ^{io_lcd_i[30:11], io_lcd_i[9]};
  assign expired   = cnt_q == '0;
  assign is_clr    = !rs_q && data_q != 8'd0 && data_q <= 8'd3;
  assign lcd_data_o = data_q;
  assign lcd_rs_o   = rs_q;
  assign lcd_rw_o   = 1'b0;
  assign lcd_en_o   = en_q;
  assign lcd_on_o   = on_q;
  assign lcd_busy_o = busy_q;
  assign lcd_done_o = done_q;
  // Sequencing: each phase loads its length-1 and advances when the counter hits zero; power-off aborts
  always_comb begin
    state_d  = state_q;
    cnt_d    = expired ? cnt_q : cnt_q - 1'b1;
    go_ack_d = go_ack_q;
    data_d   = data_q;
    rs_d     = rs_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: if (on && go != go_ack_q) begin
        state_d  = SETUP;
        cnt_d    = AS_M1;
        go_ack_d = go;
        data_d   = io_lcd_i[7:0];
        rs_d     = io_lcd_i[8];
      end
      SETUP: if (expired) begin
        state_d = PULSE;
        cnt_d   = PW_M1;
      end
      PULSE: if (expired) begin
        state_d = HOLD;
        cnt_d   = H_M1;
      end
      HOLD: if (expired) begin
        state_d = WAIT;
        cnt_d   = is_clr ? CLR_M1 : EXEC_M1;
      end
      WAIT: if (expired) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (state_q != IDLE && !on) begin
      state_d  = IDLE;
      cnt_d    = '0;
      go_ack_d = go;
      done_d   = 1'b0;
    end
    en_d   = state_d == PULSE;
    busy_d = state_d != IDLE;
  end
  // State, command and output registers; outputs mirror the next state so they come straight from flops
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      go_ack_q <= 1'b0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      on_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      go_ack_q <= go_ack_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      on_q     <= on;
    end
  end
endmodule

// File: tb/tb_lcd_ctrl.sv
// tb_lcd_ctrl: directed-vector bench for lcd_ctrl with short timing parameters
module tb_lcd_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [31:0] io_lcd_i = '0;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_busy_o, lcd_done_o;
  int          vectors = 0;
  int          miscompares = 0;
  int          n;
  lcd_ctrl #(.T_AS(2), .T_PW(3), .T_H(2), .T_EXEC(10), .T_CLR(40), .CNT_W(17)) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .io_lcd_i(io_lcd_i),
    .lcd_data_o(lcd_data_o),
    .lcd_rs_o(lcd_rs_o),
    .lcd_rw_o(lcd_rw_o),
    .lcd_en_o(lcd_en_o),
    .lcd_on_o(lcd_on_o),
    .lcd_busy_o(lcd_busy_o),
    .lcd_done_o(lcd_done_o)
  );
  // 10 ns clock
  always #5 clk_i = ~clk_i;
  wire [13:0] outs = {lcd_data_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_on_o, lcd_busy_o, lcd_done_o};
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // counts busy cycles from the current one; returns on the first non-busy cycle
  task automatic count_busy(output int cnt);
    cnt = 0;
    while (lcd_busy_o && cnt < 300) begin
      cnt++;
      tick();
    end
  endtask
  initial begin
    // 1: reset with random input, then release with zero input
    io_lcd_i = $urandom;
    #23;
    chk("reset_outs", 32'(outs), 32'h0);
    io_lcd_i = '0;
    tick();
    rst_ni = 1'b1;
    repeat (3) tick();
    chk("post_reset_outs", 32'(outs), 32'h0);
    // 2: data write 0x41; accept at cycle N (current), check N+1..N+18
    io_lcd_i = 32'h8000_0541;
    for (int i = 1; i <= 18; i++) begin
      tick();
      chk($sformatf("t2_cyc%0d_busy_en_done", i), {29'd0, lcd_busy_o, lcd_en_o, lcd_done_o},
          {29'd0, 1'(i <= 17), 1'(i >= 3 && i <= 5), 1'(i == 18)});
      if (i == 1 || i == 18) chk($sformatf("t2_cyc%0d_data_rs_on", i), {22'd0, lcd_data_o, lcd_rs_o, lcd_on_o},
                                 {22'd0, 8'h41, 1'b1, 1'b1});
    end
    // 3: clear command accepted on the done cycle, long execution wait
    io_lcd_i = 32'h8000_0001;
    tick();
    chk("t3_data_rs", {23'd0, lcd_data_o, lcd_rs_o}, {23'd0, 8'h01, 1'b0});
    count_busy(n);
    chk("t3_busy_len", n, 47);
    chk("t3_done", 32'(lcd_done_o), 32'h1);
    // 4a: single GO toggle mid-WAIT is picked up on the done cycle
    io_lcd_i = 32'h8000_0541;
    tick();
    repeat (9) tick();
    io_lcd_i = 32'h8000_0042;
    count_busy(n);
    chk("t4a_first_len", n, 8);
    chk("t4a_done", 32'(lcd_done_o), 32'h1);
    tick();
    chk("t4a_rebusy", {23'd0, lcd_busy_o, lcd_data_o}, {23'd0, 1'b1, 8'h42});
    chk("t4a_rs", 32'(lcd_rs_o), 32'h0);
    count_busy(n);
    chk("t4a_second_len", n, 17);
    chk("t4a_done2", 32'(lcd_done_o), 32'h1);
    // 4b: double toggle mid-WAIT is lost
    io_lcd_i = 32'h8000_0443;
    tick();
    repeat (9) tick();
    io_lcd_i = 32'h8000_0043;
    tick();
    io_lcd_i = 32'h8000_0443;
    count_busy(n);
    chk("t4b_len", n, 7);
    chk("t4b_done", 32'(lcd_done_o), 32'h1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("t4b_idle%0d_busy_done", i), {30'd0, lcd_busy_o, lcd_done_o}, 32'h0);
    end
    chk("t4b_data_kept", 32'(lcd_data_o), 32'h43);
    // 5: power off during PULSE aborts
    io_lcd_i = 32'h8000_0144;
    repeat (3) tick();
    chk("t5_en_pulse", 32'(lcd_en_o), 32'h1);
    io_lcd_i = 32'h0000_0144;
    tick();
    chk("t5_abort_en_busy_done_on", {28'd0, lcd_en_o, lcd_busy_o, lcd_done_o, lcd_on_o}, 32'h0);
    repeat (3) tick();
    chk("t5_no_done", {30'd0, lcd_busy_o, lcd_done_o}, 32'h0);
    io_lcd_i = 32'h8000_0144;
    repeat (3) tick();
    chk("t5_repower_on_busy", {30'd0, lcd_on_o, lcd_busy_o}, 32'h2);
    // 6: async reset mid-WAIT
    io_lcd_i = 32'h8000_0545;
    tick();
    repeat (9) tick();
    chk("t6_busy_before", 32'(lcd_busy_o), 32'h1);
    #2;
    rst_ni = 1'b0;
    io_lcd_i = 32'h8000_0045;
    #1;
    chk("t6_async_outs", 32'(outs), 32'h0);
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t6_quiet%0d_busy_done", i), {30'd0, lcd_busy_o, lcd_done_o}, 32'h0);
    end
    chk("t6_on", 32'(lcd_on_o), 32'h1);
    io_lcd_i = 32'h8000_0446;
    tick();
    chk("t6_new_data", 32'(lcd_data_o), 32'h46);
    count_busy(n);
    chk("t6_len", n, 17);
    chk("t6_done", 32'(lcd_done_o), 32'h1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
